// File: rtl/shift_l_reg_n.sv
// shift_l_reg_n
// N-bit left-shift register with parallel load and clock enable.
//
// Ports:
//   clk  - single clock, all state updates on its rising edge
//   rst  - asynchronous, active-low clear of the register
//   en   - clock enable; 1 = load or shift on the edge, 0 = hold
//   ldsh - operation select; 1 = parallel load from d, 0 = shift left
//   SI   - serial shift-in bit, enters at bit 0 during a shift
//   d    - parallel load data (N bits)
//   q    - register contents (N bits)
//   SO   - serial shift-out bit, always q[N-1]
//
// Priority on each edge: reset low, then enable low (hold), then load over shift.

module shift_l_reg_n #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         ldsh,
    input  logic         SI,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         SO
);

    logic [N-1:0] shiftReg;

    // The shift is logical: bit 0 is always fed from SI and the old MSB
    // is simply dropped, leaving the register only through SO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shiftReg <= '0;
        end else if (en) begin
            if (ldsh) begin
                shiftReg <= d;
            end else begin
                shiftReg <= {shiftReg[N-2:0], SI};
            end
        end
    end

    assign q  = shiftReg;
    assign SO = shiftReg[N-1];

endmodule

// File: tb/tb_shift_l_reg_n.sv
// tb_shift_l_reg_n
// Directed testbench for shift_l_reg_n (N = 8): reset, load, shift, hold,
// fill/flush and reset release, with hand-computed expected values.

module tb_shift_l_reg_n;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic         ldsh;
    logic         SI;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         SO;

    int errorCount = 0;
    int checkCount = 0;

    shift_l_reg_n #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .ldsh (ldsh),
        .SI   (SI),
        .d    (d),
        .q    (q),
        .SO   (SO)
    );

    // 10 ns clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [N-1:0] actual,
                               input logic [N-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive inputs between edges, take one rising edge, then settle 1 ns.
    task automatic applyStimulus(input logic enIn, input logic ldshIn,
                                 input logic siIn, input logic [N-1:0] dIn);
        en   = enIn;
        ldsh = ldshIn;
        SI   = siIn;
        d    = dIn;
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] qModel;

    initial begin
        rst  = 1'b0;
        en   = 1'b0;
        ldsh = 1'b0;
        SI   = 1'b0;
        d    = '0;

        // Reset state
        @(posedge clk);
        #1;
        checkOutput("reset_q", q, 8'h00);
        checkOutput("reset_so", {7'b0, SO}, 8'h00);
        #2 rst = 1'b1;

        // Load A5
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5);
        checkOutput("load_q", q, 8'hA5);
        checkOutput("load_so", {7'b0, SO}, 8'h01);

        // Shift with SI=1, then SI=0
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
        checkOutput("shift1_q", q, 8'h4B);
        checkOutput("shift1_so", {7'b0, SO}, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("shift2_q", q, 8'h96);
        checkOutput("shift2_so", {7'b0, SO}, 8'h01);

        // Hold for 3 edges with en=0 regardless of other inputs
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
            checkOutput($sformatf("hold%0d_q", i), q, 8'h96);
        end

        // Inputs changing between edges must not disturb q
        en   = 1'b1;
        ldsh = 1'b1;
        #1 d = 8'h3C;
        #1 d = 8'hC3;
        checkOutput("midcycle_q", q, 8'h96);

        // Reload A5, then assert reset between edges
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5);
        checkOutput("reload_q", q, 8'hA5);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_q", q, 8'h00);
        checkOutput("async_rst_so", {7'b0, SO}, 8'h00);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF);
            checkOutput($sformatf("rst_hold%0d_q", i), q, 8'h00);
            checkOutput($sformatf("rst_hold%0d_so", i), {7'b0, SO}, 8'h00);
        end

        // Reset release: first edge performs a normal shift
        #2 rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF);
        checkOutput("release_q", q, 8'h01);

        // Clear again, then fill and flush
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        qModel = 8'h00;
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
            qModel = {qModel[N-2:0], 1'b1};
            checkOutput($sformatf("fill%0d_q", i), q, qModel);
            checkOutput($sformatf("fill%0d_so", i), {7'b0, SO}, {7'b0, qModel[N-1]});
        end
        checkOutput("fill_done_q", q, 8'hFF);
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF);
            qModel = {qModel[N-2:0], 1'b0};
            checkOutput($sformatf("flush%0d_q", i), q, qModel);
            checkOutput($sformatf("flush%0d_so", i), {7'b0, SO},
                        (i < N - 1) ? 8'h01 : 8'h00);
        end
        checkOutput("flush_done_q", q, 8'h00);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
